// File: rtl/fp_result_reader.sv
// ---------------------------------------------------------------------------
// fp_result_reader
//
// Output-end reader of the filter pipeline. Captures one batch of per-lane
// match bitmaps (bit k set = record id k passed every filter stage) and
// serializes every set bit as an id entry on a valid/ready stream. Ids come
// out ascending within a lane and lanes are visited in ascending order. A
// valid lane whose bitmap is all zero produces a single "empty" marker so
// the downstream collector still sees that lane; invalid lanes are skipped.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous active-low reset
//   in             INPUTS x BIT_VEC_SIZE lane bitmaps
//   valid_in       per-lane bitmap valid
//   in_ready       block is idle and can capture a batch
//   out_id         emitted record id (0 for an empty marker)
//   out_lane       lane the entry belongs to
//   out_empty      entry is an empty-lane marker
//   out_last_lane  final entry of its lane
//   out_last       final entry of the batch
//   out_valid      entry valid
//   out_ready      downstream accepts the entry
//   batch_cnt      completed batches, wraps at 16 bits
// ---------------------------------------------------------------------------
module fp_result_reader #(
    parameter int INPUTS           = 2,
    parameter int LANE_LOG         = 1,
    parameter int BIT_VEC_SIZE     = 128,
    parameter int BIT_VEC_SIZE_LOG = 7
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [INPUTS-1:0][BIT_VEC_SIZE-1:0]  in,
    input  logic [INPUTS-1:0]                    valid_in,
    output logic                                 in_ready,
    output logic [BIT_VEC_SIZE_LOG-1:0]          out_id,
    output logic [LANE_LOG-1:0]                  out_lane,
    output logic                                 out_empty,
    output logic                                 out_last_lane,
    output logic                                 out_last,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [15:0]                          batch_cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t                                r_state;
    logic [INPUTS-1:0][BIT_VEC_SIZE-1:0]   r_buf;
    logic [INPUTS-1:0]                     r_lmask;
    logic [BIT_VEC_SIZE_LOG-1:0]           r_out_id;
    logic [LANE_LOG-1:0]                   r_out_lane;
    logic                                  r_out_empty;
    logic                                  r_out_last_lane;
    logic                                  r_out_last;
    logic                                  r_out_valid;
    logic [15:0]                           r_batch_cnt;

    logic [LANE_LOG-1:0]                   w_cur;
    logic [BIT_VEC_SIZE-1:0]               w_bits;
    logic [BIT_VEC_SIZE-1:0]               w_rem;
    logic [BIT_VEC_SIZE_LOG-1:0]           w_id;
    logic [INPUTS-1:0]                     w_others;
    logic                                  w_empty;
    logic                                  w_last_lane;
    logic                                  w_last;
    logic                                  w_load;
    logic                                  w_capture;

    // Selection of the next entry: lowest pending lane, then the lowest set
    // bit of that lane's remaining bitmap.
    always_comb begin
        // NOTE: every signal gets a default before the loops so no path
        // leaves a value unassigned and no latch is inferred.
        w_cur = '0;
        for (int j = INPUTS - 1; j >= 0; j--) begin
            if (r_lmask[j]) begin
                w_cur = LANE_LOG'(j);
            end
        end

        w_bits = r_buf[w_cur];

        w_id = '0;
        for (int k = BIT_VEC_SIZE - 1; k >= 0; k--) begin
            if (w_bits[k]) begin
                w_id = BIT_VEC_SIZE_LOG'(k);
            end
        end

        // A pending lane whose bitmap is already zero can only be on its first
        // visit: the lane's mask bit clears together with its last set bit.
        w_empty     = (w_bits == '0);
        w_rem       = w_bits & ~(BIT_VEC_SIZE'(1) << w_id);
        w_last_lane = (w_rem == '0);
        w_others    = r_lmask & ~(INPUTS'(1) << w_cur);
        w_last      = w_last_lane && (w_others == '0);
    end

    // The output register takes a new entry whenever it is empty or its
    // current entry is being accepted this cycle.
    assign w_load    = (r_state == DRAIN) && (!r_out_valid || out_ready);
    assign w_capture = (r_state == IDLE) && (|valid_in);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state         <= IDLE;
            // NOTE: the capture buffers are cleared with everything else so a
            // reset in the middle of a drain leaves no stale bits behind.
            r_buf           <= '0;
            r_lmask         <= '0;
            r_out_id        <= '0;
            r_out_lane      <= '0;
            r_out_empty     <= 1'b0;
            r_out_last_lane <= 1'b0;
            r_out_last      <= 1'b0;
            r_out_valid     <= 1'b0;
            r_batch_cnt     <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch reads
            // the pre-edge state regardless of statement order.
            if (w_load) begin
                r_out_valid     <= 1'b1;
                r_out_id        <= w_id;
                r_out_lane      <= w_cur;
                r_out_empty     <= w_empty;
                r_out_last_lane <= w_last_lane;
                r_out_last      <= w_last;
                r_buf[w_cur]    <= w_rem;
                if (w_last_lane) begin
                    r_lmask[w_cur] <= 1'b0;
                end
                if (w_last) begin
                    r_state     <= IDLE;
                    r_batch_cnt <= r_batch_cnt + 16'd1;
                end
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end

            // Only possible in IDLE, so it never collides with a load. The
            // previous batch's final entry may still sit in the output
            // register; the new batch's first load waits for it to transfer.
            if (w_capture) begin
                r_buf   <= in;
                r_lmask <= valid_in;
                r_state <= DRAIN;
            end
        end
    end

    // Held low while reset is asserted, even though the state is already IDLE.
    assign in_ready      = rst && (r_state == IDLE);
    assign out_id        = r_out_id;
    assign out_lane      = r_out_lane;
    assign out_empty     = r_out_empty;
    assign out_last_lane = r_out_last_lane;
    assign out_last      = r_out_last;
    assign out_valid     = r_out_valid;
    assign batch_cnt     = r_batch_cnt;

endmodule

// File: tb/tb_fp_result_reader.sv
// ---------------------------------------------------------------------------
// Bench for fp_result_reader (INPUTS=2, 128-bit bitmaps).
// A reference model turns each captured batch into the list of entries it
// must produce; a negedge monitor compares every accepted entry against it
// and checks that a stalled entry holds still.
// ---------------------------------------------------------------------------
module tb_fp_result_reader;

    typedef struct packed {
        logic       lane;
        logic [6:0] id;
        logic       empty;
        logic       last_lane;
        logic       last;
    } entry_t;

    typedef struct {
        logic [1:0]   valid;
        logic [127:0] in0;
        logic [127:0] in1;
        int           exp_count;
        entry_t       exp_first;
        entry_t       exp_last;
    } vec_t;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [1:0][127:0]   in_vec = '0;
    logic [1:0]          valid_in = '0;
    logic                in_ready;
    logic [6:0]          out_id;
    logic [0:0]          out_lane;
    logic                out_empty;
    logic                out_last_lane;
    logic                out_last;
    logic                out_valid;
    logic                out_ready = 1'b1;
    logic [15:0]         batch_cnt;

    logic                fixed_ready = 1'b1;
    logic                rand_ready  = 1'b0;

    int                  total = 0;
    int                  bad   = 0;
    int                  cyc   = 0;

    entry_t              exp_q[$];
    logic [15:0]         model_batch = '0;

    int                  obs_count = 0;
    int                  obs_first_cyc = 0;
    int                  obs_last_cyc = 0;
    entry_t              obs_first;
    entry_t              obs_last;
    entry_t              mon_e;
    entry_t              hold_val;
    logic                hold = 1'b0;

    vec_t                vecs[6];

    fp_result_reader #(
        .INPUTS(2),
        .LANE_LOG(1),
        .BIT_VEC_SIZE(128),
        .BIT_VEC_SIZE_LOG(7)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in(in_vec),
        .valid_in(valid_in),
        .in_ready(in_ready),
        .out_id(out_id),
        .out_lane(out_lane),
        .out_empty(out_empty),
        .out_last_lane(out_last_lane),
        .out_last(out_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .batch_cnt(batch_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : fixed_ready;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic entry_t mk(input logic lane, input int id, input logic empty,
                                  input logic last_lane, input logic last);
        entry_t e;
        e.lane      = lane;
        e.id        = 7'(id);
        e.empty     = empty;
        e.last_lane = last_lane;
        e.last      = last;
        return e;
    endfunction

    // Entries a batch must produce: set bits in ascending order per valid lane,
    // a marker for an all-zero valid lane, lane end and batch end flagged.
    task automatic model_push(input logic [1:0] v, input logic [127:0] a, input logic [127:0] b);
        logic [127:0] bits;
        entry_t       e;
        entry_t       lane_q[$];
        entry_t       batch_q[$];
        for (int ln = 0; ln < 2; ln++) begin
            if (v[ln]) begin
                bits = (ln == 0) ? a : b;
                lane_q.delete();
                if (bits == '0) begin
                    lane_q.push_back(mk(1'(ln), 0, 1'b1, 1'b0, 1'b0));
                end else begin
                    for (int k = 0; k < 128; k++) begin
                        if (bits[k]) lane_q.push_back(mk(1'(ln), k, 1'b0, 1'b0, 1'b0));
                    end
                end
                e = lane_q.pop_back();
                e.last_lane = 1'b1;
                lane_q.push_back(e);
                foreach (lane_q[i]) batch_q.push_back(lane_q[i]);
            end
        end
        e = batch_q.pop_back();
        e.last = 1'b1;
        batch_q.push_back(e);
        foreach (batch_q[i]) exp_q.push_back(batch_q[i]);
    endtask

    // Present a batch for exactly one capture edge; returns 1 time unit
    // after that edge.
    task automatic send_batch(input logic [1:0] v, input logic [127:0] a, input logic [127:0] b);
        int t = 0;
        @(negedge clk);
        while (!in_ready && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 3000) check("in_ready_timeout", in_ready, 1);
        valid_in  = v;
        in_vec[0] = a;
        in_vec[1] = b;
        model_push(v, a, b);
        model_batch = model_batch + 16'd1;
        @(posedge clk);
        #1;
        valid_in = '0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((exp_q.size() != 0 || out_valid) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("drain_pending_entries", exp_q.size(), 0);
    endtask

    function automatic logic [127:0] rnd_vec();
        logic [127:0] r;
        int           m;
        m = $urandom_range(0, 3);
        r = {$urandom, $urandom, $urandom, $urandom};
        case (m)
            0:       return '0;
            1:       return r & {$urandom, $urandom, $urandom, $urandom}
                          & {$urandom, $urandom, $urandom, $urandom};
            2:       return r;
            default: return 128'(1) << $urandom_range(0, 127);
        endcase
    endfunction

    // Scoreboard: every accepted entry must be the next expected one, and a
    // stalled entry must not change until it is accepted.
    always @(negedge clk) begin
        if (!rst) begin
            hold = 1'b0;
        end else begin
            mon_e = '{lane: out_lane, id: out_id, empty: out_empty,
                      last_lane: out_last_lane, last: out_last};
            if (hold) check("stall_hold", {out_valid, mon_e}, {1'b1, hold_val});
            if (out_valid && out_ready) begin
                check("entry_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    check("entry", mon_e, exp_q[0]);
                    void'(exp_q.pop_front());
                end
                if (obs_count == 0) begin
                    obs_first     = mon_e;
                    obs_first_cyc = cyc;
                end
                obs_last     = mon_e;
                obs_last_cyc = cyc;
                obs_count++;
            end
            hold     = out_valid && !out_ready;
            hold_val = mon_e;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;

        vecs[0] = '{valid: 2'b01, in0: 128'h29, in1: 128'h0, exp_count: 3,
                    exp_first: mk(1'b0, 0, 1'b0, 1'b0, 1'b0),
                    exp_last:  mk(1'b0, 5, 1'b0, 1'b1, 1'b1)};
        vecs[1] = '{valid: 2'b11, in0: 128'h0, in1: {1'b1, 127'h0}, exp_count: 2,
                    exp_first: mk(1'b0, 0, 1'b1, 1'b1, 1'b0),
                    exp_last:  mk(1'b1, 127, 1'b0, 1'b1, 1'b1)};
        vecs[2] = '{valid: 2'b10, in0: 128'h55, in1: {128{1'b1}}, exp_count: 128,
                    exp_first: mk(1'b1, 0, 1'b0, 1'b0, 1'b0),
                    exp_last:  mk(1'b1, 127, 1'b0, 1'b1, 1'b1)};
        vecs[3] = '{valid: 2'b11, in0: {1'b1, 126'h0, 1'b1}, in1: 128'h0, exp_count: 3,
                    exp_first: mk(1'b0, 0, 1'b0, 1'b0, 1'b0),
                    exp_last:  mk(1'b1, 0, 1'b1, 1'b1, 1'b1)};
        vecs[4] = '{valid: 2'b01, in0: 128'h6, in1: 128'hFF, exp_count: 2,
                    exp_first: mk(1'b0, 1, 1'b0, 1'b0, 1'b0),
                    exp_last:  mk(1'b0, 2, 1'b0, 1'b1, 1'b1)};
        vecs[5] = '{valid: 2'b11, in0: 128'h0, in1: 128'h0, exp_count: 2,
                    exp_first: mk(1'b0, 0, 1'b1, 1'b1, 1'b0),
                    exp_last:  mk(1'b1, 0, 1'b1, 1'b1, 1'b1)};

        // Reset state
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_batch_cnt", batch_cnt, 0);
        check("rst_out_fields", {out_id, out_lane, out_empty, out_last_lane, out_last}, 0);
        rst = 1'b1;
        #1;
        check("release_in_ready", in_ready, 1);

        // Directed table, downstream always ready
        for (int i = 0; i < 6; i++) begin
            obs_count = 0;
            send_batch(vecs[i].valid, vecs[i].in0, vecs[i].in1);
            @(negedge clk);
            check("no_entry_before_E1", out_valid, 0);
            check("busy_after_capture", in_ready, 0);
            @(negedge clk);
            check("entry_valid_after_E1", out_valid, 1);
            wait_drain();
            check("vec_count", obs_count, vecs[i].exp_count);
            check("vec_first", obs_first, vecs[i].exp_first);
            check("vec_last", obs_last, vecs[i].exp_last);
            check("vec_one_per_cycle", obs_last_cyc - obs_first_cyc + 1, vecs[i].exp_count);
            check("vec_batch_cnt", batch_cnt, model_batch);
            check("vec_in_ready", in_ready, 1);
        end

        // Backpressure: id 1 must hold through the stall
        @(negedge clk);
        fixed_ready = 1'b0;
        send_batch(2'b01, 128'h6, 128'h0);
        @(negedge clk);
        repeat (3) begin
            @(negedge clk);
            check("bp_hold_id1", {out_valid, out_id}, {1'b1, 7'd1});
        end
        fixed_ready = 1'b1;
        wait_drain();
        check("bp_batch_cnt", batch_cnt, model_batch);

        // Overlap: next batch captured while the final entry still waits
        @(negedge clk);
        fixed_ready = 1'b0;
        send_batch(2'b01, 128'h1, 128'h0);
        send_batch(2'b01, 128'h3, 128'h0);
        @(negedge clk);
        check("ovl_old_entry_held", {out_valid, out_id, out_last}, {1'b1, 7'd0, 1'b1});
        check("ovl_captured", in_ready, 0);
        fixed_ready = 1'b1;
        wait_drain();
        check("ovl_batch_cnt", batch_cnt, model_batch);

        // Randomized batches with random downstream readiness
        rand_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            send_batch(2'($urandom_range(1, 3)), rnd_vec(), rnd_vec());
        end
        wait_drain();
        rand_ready = 1'b0;
        check("rand_batch_cnt", batch_cnt, model_batch);

        // Reset mid-drain after two of five ids
        @(negedge clk);
        obs_count = 0;
        send_batch(2'b01, 128'h1F, 128'h0);
        t = 0;
        while (obs_count < 2 && t < 100) begin
            @(posedge clk);
            t++;
        end
        check("mid_two_emitted", obs_count, 2);
        #2;
        rst = 1'b0;
        exp_q.delete();
        model_batch = '0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_batch_cnt", batch_cnt, 0);
        check("mid_rst_in_ready", in_ready, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_release_in_ready", in_ready, 1);
        repeat (10) @(negedge clk);
        check("mid_no_resume", {out_valid, 32'(obs_count)}, {1'b0, 32'd2});

        // Counter wrap from a preloaded count
        @(negedge clk);
        force dut.r_batch_cnt = 16'hFFFE;
        #1;
        release dut.r_batch_cnt;
        model_batch = 16'hFFFE;
        check("wrap_preload", batch_cnt, 16'hFFFE);
        send_batch(2'b01, 128'h4, 128'h0);
        wait_drain();
        check("wrap_ffff", batch_cnt, 16'hFFFF);
        send_batch(2'b10, 128'h0, 128'h8);
        wait_drain();
        check("wrap_zero", batch_cnt, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fp_result_reader.md
Name: fp_result_reader

Overview:
- Consumer at the output end of the filter pipeline (fp).
- Each pipeline output lane delivers a BIT_VEC_SIZE match bitmap, where bit k set means record id k passed all filter stages.
- This block captures one batch of lane bitmaps, then serializes each set bit into an id stream with valid/ready handshake: ascending id within a lane, ascending lane order.
- It is the reader for the bitmaps the pipeline writes, feeding the downstream result collector.

Parameters:
- INPUTS, 2, number of pipeline output lanes.
- LANE_LOG, 1, width of the lane index (clog2(INPUTS), minimum 1).
- BIT_VEC_SIZE, 128, bitmap width.
- BIT_VEC_SIZE_LOG, 7, width of an id.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- in  in  [BIT_VEC_SIZE-1:0] x INPUTS  lane bitmaps from the fp out array.
- valid_in  in  1 x INPUTS  per-lane bitmap valid.
- in_ready  out  1  block can capture a batch.
- out_id  out  BIT_VEC_SIZE_LOG  emitted record id.
- out_lane  out  LANE_LOG  lane the id came from.
- out_empty  out  1  marker entry: lane bitmap was all-zero; out_id = 0.
- out_last_lane  out  1  final entry of the current lane.
- out_last  out  1  final entry of the batch.
- out_valid  out  1  entry valid.
- out_ready  in  1  downstream accepts the entry.
- batch_cnt  out  16  number of completed batches; wraps at 0xFFFF -> 0.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - Capture buffers and the lane mask clear.
  - out_valid, out_id, out_lane, out_empty, out_last_lane, out_last and batch_cnt all go to 0.
  - in_ready = 0 while rst is low; in_ready = 1 on the first cycle after release.
  - Reset mid-drain discards the batch; no partial output resumes.
- States: IDLE, DRAIN.
- in_ready = (state == IDLE).
- Capture:
  - Occurs in IDLE when any valid_in[j] = 1.
  - At that edge, buf[j] <= in[j] and lmask[j] <= valid_in[j] for every lane j.
  - State goes to DRAIN.
  - Lanes with valid_in = 0 are skipped entirely: no output, including no empty marker.
- Current lane: lowest j with lmask[j] = 1.
- Current id: lowest set bit of buf[cur] (combinational priority encoder).
- Output register load condition: (!out_valid || out_ready) in DRAIN.
  - If buf[cur] != 0: out_id = lowest set bit, out_empty = 0. Clear that bit in buf[cur].
  - If buf[cur] == 0 at first visit: emit out_empty = 1, out_id = 0.
  - out_last_lane = 1 when no bits remain in buf[cur] after this load, or for an empty marker; then clear lmask[cur].
  - out_last = out_last_lane AND no other lmask bits remain. On that load, state returns to IDLE and batch_cnt increments.
- Handshake:
  - An entry transfers on out_valid && out_ready.
  - If out_ready = 0, all out_* signals hold stable.
  - If no load occurs while out_ready = 1, out_valid falls to 0.
- Latency:
  - Capture at edge E0; first entry valid after E1.
  - One entry per cycle under continuous out_ready = 1.
  - Batch output count = sum of popcounts, plus one per empty valid lane.
- Overlap: a new batch may be captured while the previous batch's final entry still waits in the output register. The next batch's entries load only after that entry transfers.
- A simultaneous capture and final-entry transfer in the same cycle is legal.
- An all-ones lane of 128 bits takes exactly 128 entries; id 127 carries out_last_lane.

Test Plan:
- Single lane: valid_in = {0,1}, in[0] = 0x...0029 -> ids 0, 3, 5 on lane 0, each with out_ready = 1 held. id 5 has out_last_lane = 1 and out_last = 1. batch_cnt = 1. in_ready is high again after the load of id 5.
- Two lanes, one empty: in[0] = 0, in[1] = bit127 set -> entry 1 is (lane 0, empty = 1, id 0, last_lane = 1, last = 0). Entry 2 is (lane 1, id 127, last = 1).
- Backpressure: in[0] = 0x6, out_ready toggling 1,0,0,1 -> id 1 held stable for three cycles. No id is duplicated or dropped.
- Full vector: in[1] = all ones, lane 0 invalid -> 128 consecutive ids 0..127 in 128 cycles, all out_lane = 1. Only id 127 has out_last = 1.
- Reset mid-drain: rst low after 2 of 5 ids emitted -> out_valid = 0 immediately and batch_cnt = 0. After release, in_ready = 1 and the remaining ids are never emitted.
- Wrap: preload 65535 batches -> the next batch completes with batch_cnt = 0.
